jtsbaskt_sndlatch: RTL and testbench

Sound-side receiver for the main-to-sound command channel.
- Main CPU side: writes a command byte (cpu_dout qualified by m2s_data) and raises a "sound on" trigger (m2s_irq).
- This block captures command bytes into a small FIFO and drives the sound CPU IRQ line.
- The sound CPU reads bytes through snd_latch and acknowledges the IRQ.
- Sits between jtsbaskt_main outputs and the jtsbaskt_snd CPU bus, all in the clk24 domain.

---
 rtl/jtsbaskt_sndlatch.sv | 193 +++++++++++++++++++
 tb/tb_jtsbaskt_sndlatch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jtsbaskt_sndlatch.sv
// -----------------------------------------------------------------------------
// jtsbaskt_sndlatch
//
// Sound-side receiver for the main-to-sound command channel (clk24 domain).
// The main CPU writes command bytes (rising edge of m2s_data) and raises a
// "sound on" request (rising edge of m2s_irq). Command bytes are queued in a
// small FIFO; the sound CPU sees the head byte on snd_latch and pops it with
// snd_rd. The request drives an active-low IRQ that the sound CPU acknowledges.
//
// Ports:
//   clk          24 MHz system clock
//   rst_n        asynchronous active-low reset
//   main_dout    command byte from the main CPU data bus
//   m2s_data     latch chip select (level, rising edge = write)
//   m2s_irq      sound-on trigger (level, rising edge = IRQ request)
//   snd_cen      sound CPU clock enable, qualifies snd_rd and snd_irq_ack
//   snd_rd       sound CPU latch read strobe, pops the FIFO head
//   snd_irq_ack  sound CPU IRQ acknowledge
//   snd_latch    command byte presented to the sound CPU (registered)
//   snd_irqn     active-low IRQ to the sound CPU (registered)
//   fifo_cnt     number of stored entries, 0..2**AW
//   ovf          sticky: a write was dropped because the FIFO was full
//   irq_miss     sticky: a request arrived while one was already pending
//
// Handshake: there is no back-pressure toward the main CPU. A write edge is
// accepted whenever the FIFO has room at that clock (a same-clock pop of a
// full FIFO counts as room); otherwise it is dropped and flagged in ovf.
// A pop (snd_cen & snd_rd) on an empty FIFO is ignored.
// -----------------------------------------------------------------------------
module jtsbaskt_sndlatch #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    main_dout,
    input  logic          m2s_data,
    input  logic          m2s_irq,
    input  logic          snd_cen,
    input  logic          snd_rd,
    input  logic          snd_irq_ack,
    output logic [7:0]    snd_latch,
    output logic          snd_irqn,
    output logic [AW:0]   fifo_cnt,
    output logic          ovf,
    output logic          irq_miss
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        IRQ_IDLE = 1'b0,
        IRQ_PEND = 1'b1
    } irq_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          m2s_data_l_q, m2s_data_l_d;
    logic          m2s_irq_l_q,  m2s_irq_l_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    latch_q, latch_d;
    logic          ovf_q, ovf_d;
    logic          irq_miss_q, irq_miss_d;
    irq_state_t    irq_state_q, irq_state_d;

    // ------------------------------------------------------------------
    // Events
    // ------------------------------------------------------------------
    logic wr, req, rd, ack;
    logic full, empty;
    logic push, pop;

    always_comb begin
        // History registers start at 0, so a level already high when reset
        // is released is seen as an edge on the first clock.
        wr    = m2s_data & ~m2s_data_l_q;
        req   = m2s_irq  & ~m2s_irq_l_q;
        rd    = snd_cen  & snd_rd;
        ack   = snd_cen  & snd_irq_ack;
        full  = (cnt_q == FULL_CNT);
        empty = (cnt_q == '0);
        // A full FIFO still accepts a write when the head leaves on the
        // same clock; an empty FIFO never pops, even alongside a write.
        push  = wr & (~full | rd);
        pop   = rd & ~empty;
    end

    // ------------------------------------------------------------------
    // FIFO / latch next state
    // ------------------------------------------------------------------
    always_comb begin
        m2s_data_l_d = m2s_data;
        m2s_irq_l_d  = m2s_irq;
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        ovf_d        = ovf_q | (wr & ~push);

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase

        // The latch follows the registered head, which places new data on
        // snd_latch one clock after the push (empty FIFO) or pop edge.
        latch_d = latch_q;
        if (!empty) begin
            latch_d = mem_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // IRQ FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        irq_state_d = irq_state_q;
        irq_miss_d  = irq_miss_q;
        case (irq_state_q)
            IRQ_IDLE: begin
                // An acknowledge with nothing pending is ignored.
                if (req) begin
                    irq_state_d = IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                if (req) begin
                    // A request coinciding with the acknowledge re-arms the
                    // IRQ instead of being lost, so it is not a miss.
                    irq_state_d = IRQ_PEND;
                    if (!ack) begin
                        irq_miss_d = 1'b1;
                    end
                end else if (ack) begin
                    irq_state_d = IRQ_IDLE;
                end
            end
            default: begin
                irq_state_d = IRQ_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2s_data_l_q <= 1'b0;
            m2s_irq_l_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            latch_q      <= 8'h00;
            ovf_q        <= 1'b0;
            irq_miss_q   <= 1'b0;
            irq_state_q  <= IRQ_IDLE;
        end else begin
            m2s_data_l_q <= m2s_data_l_d;
            m2s_irq_l_q  <= m2s_irq_l_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            latch_q      <= latch_d;
            ovf_q        <= ovf_d;
            irq_miss_q   <= irq_miss_d;
            irq_state_q  <= irq_state_d;
        end
    end

    // Storage needs no reset: contents are only observed through cnt_q.
    // When full with a same-clock pop, wr_ptr equals rd_ptr; the latch has
    // already sampled the old head, so overwriting it here is safe.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= main_dout;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign snd_latch = latch_q;
    assign snd_irqn  = (irq_state_q == IRQ_IDLE);
    assign fifo_cnt  = cnt_q;
    assign ovf       = ovf_q;
    assign irq_miss  = irq_miss_q;

endmodule

// File: tb/tb_jtsbaskt_sndlatch.sv
module tb_jtsbaskt_sndlatch;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  main_dout = 8'h00;
    logic        m2s_data = 1'b0;
    logic        m2s_irq = 1'b0;
    logic        snd_cen = 1'b0;
    logic        snd_rd = 1'b0;
    logic        snd_irq_ack = 1'b0;
    logic [7:0]  snd_latch;
    logic        snd_irqn;
    logic [AW:0] fifo_cnt;
    logic        ovf;
    logic        irq_miss;

    jtsbaskt_sndlatch #(.AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .main_dout   (main_dout),
        .m2s_data    (m2s_data),
        .m2s_irq     (m2s_irq),
        .snd_cen     (snd_cen),
        .snd_rd      (snd_rd),
        .snd_irq_ack (snd_irq_ack),
        .snd_latch   (snd_latch),
        .snd_irqn    (snd_irqn),
        .fifo_cnt    (fifo_cnt),
        .ovf         (ovf),
        .irq_miss    (irq_miss)
    );

    // scoreboard
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic [7:0] last_pop;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // driver tasks (inputs change on the falling edge, checks sample there too)
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        main_dout = 8'h00; m2s_data = 1'b0; m2s_irq = 1'b0;
        snd_cen = 1'b0; snd_rd = 1'b0; snd_irq_ack = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        last_pop = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        main_dout = b;
        m2s_data  = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        @(negedge clk);
        m2s_data = 1'b0;
        @(negedge clk);
    endtask

    // The head must be on snd_latch before the sound CPU reads it.
    task automatic pop_check();
        if (exp_q.size() > 0) begin
            last_pop = exp_q.pop_front();
            check_eq("pop_latch", snd_latch, last_pop);
        end
        snd_cen = 1'b1;
        snd_rd  = 1'b1;
        @(negedge clk);
        snd_rd  = 1'b0;
        snd_cen = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // ---------------- test 1: reset and first write
        do_reset();
        check_eq("rst_latch", snd_latch, 8'h00);
        check_eq("rst_irqn", snd_irqn, 1);
        check_eq("rst_cnt", fifo_cnt, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_miss", irq_miss, 0);
        main_dout = 8'hA5;
        m2s_data  = 1'b1;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        m2s_data = 1'b0;
        check_eq("t1_cnt", fifo_cnt, 1);
        check_eq("t1_latch_early", snd_latch, 8'h00);
        @(negedge clk);
        check_eq("t1_latch", snd_latch, exp_q[0]);
        check_eq("t1_irqn", snd_irqn, 1);

        // ---------------- test 2: overflow and drain
        do_reset();
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        check_eq("t2_cnt", fifo_cnt, exp_q.size());
        check_eq("t2_ovf", ovf, exp_ovf);
        while (exp_q.size() > 0) pop_check();
        check_eq("t2_cnt_empty", fifo_cnt, 0);
        check_eq("t2_last", snd_latch, 8'h04);
        pop_check();
        check_eq("t2_empty_pop_latch", snd_latch, last_pop);
        check_eq("t2_empty_pop_cnt", fifo_cnt, 0);

        // ---------------- test 3: IRQ and gated acknowledge
        do_reset();
        m2s_irq = 1'b1;
        @(negedge clk);
        check_eq("t3_irqn_set", snd_irqn, 0);
        m2s_irq = 1'b0;
        snd_irq_ack = 1'b1;
        snd_cen = 1'b0;
        @(negedge clk);
        check_eq("t3_ack_nocen", snd_irqn, 0);
        snd_cen = 1'b1;
        @(negedge clk);
        check_eq("t3_ack", snd_irqn, 1);
        snd_irq_ack = 1'b0; snd_cen = 1'b0;
        @(negedge clk);
        check_eq("t3_idle", snd_irqn, 1);

        // ---------------- test 4: request vs acknowledge, missed request
        do_reset();
        m2s_irq = 1'b1;
        @(negedge clk);
        m2s_irq = 1'b0;
        @(negedge clk);
        m2s_irq = 1'b1; snd_irq_ack = 1'b1; snd_cen = 1'b1;
        @(negedge clk);
        check_eq("t4_coinc_irqn", snd_irqn, 0);
        check_eq("t4_coinc_miss", irq_miss, 0);
        m2s_irq = 1'b0; snd_irq_ack = 1'b0; snd_cen = 1'b0;
        @(negedge clk);
        m2s_irq = 1'b1;
        @(negedge clk);
        check_eq("t4_miss", irq_miss, 1);
        check_eq("t4_pend", snd_irqn, 0);
        m2s_irq = 1'b0; snd_irq_ack = 1'b1; snd_cen = 1'b1;
        @(negedge clk);
        snd_irq_ack = 1'b0; snd_cen = 1'b0;
        check_eq("t4_ack_irqn", snd_irqn, 1);
        check_eq("t4_miss_sticky", irq_miss, 1);

        // ---------------- test 5: push and pop on a full FIFO
        do_reset();
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        check_eq("t5_full", fifo_cnt, 4);
        last_pop = exp_q.pop_front();
        check_eq("t5_head", snd_latch, last_pop);
        exp_q.push_back(8'h77);
        main_dout = 8'h77; m2s_data = 1'b1; snd_rd = 1'b1; snd_cen = 1'b1;
        @(negedge clk);
        m2s_data = 1'b0; snd_rd = 1'b0; snd_cen = 1'b0;
        check_eq("t5_cnt", fifo_cnt, 4);
        check_eq("t5_ovf", ovf, 0);
        @(negedge clk);
        while (exp_q.size() > 0) pop_check();
        check_eq("t5_last", snd_latch, 8'h77);

        // ---------------- random push/pop mix against the scoreboard
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) push_byte(8'($urandom_range(0, 255)));
            else if (exp_q.size() > 0) pop_check();
            check_eq("rnd_cnt", fifo_cnt, exp_q.size());
            check_eq("rnd_ovf", ovf, exp_ovf);
        end

        // ---------------- test 6: held level, async reset, edge at release
        do_reset();
        main_dout = 8'h3C; m2s_data = 1'b1; m2s_irq = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        check_eq("t6_one_push", fifo_cnt, 1);
        check_eq("t6_latch", snd_latch, 8'h3C);
        check_eq("t6_irqn", snd_irqn, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_cnt", fifo_cnt, 0);
        check_eq("t6_async_latch", snd_latch, 8'h00);
        check_eq("t6_async_irqn", snd_irqn, 1);
        check_eq("t6_async_ovf", ovf, 0);
        check_eq("t6_async_miss", irq_miss, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_rel_push", fifo_cnt, 1);
        check_eq("t6_rel_irqn", snd_irqn, 0);
        m2s_data = 1'b0; m2s_irq = 1'b0;
        @(negedge clk);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
